// File: rtl/bsg_credit_rr_pkg.sv
// Shared types and sizing helpers for the credit-based round-robin sender.
package bsg_credit_rr_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } rr_state_e;

  // Credit counter must hold 0..els inclusive.
  function automatic int credit_cnt_w(input int els);
    return $clog2(els + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
// Zero latency; no flow control of its own, found_o is low when no request is set.
module bsg_rr_pick
  import bsg_credit_rr_pkg::*;
#(
  parameter  int num_req_p = 4,
  localparam int idx_w_lp  = idx_w(num_req_p)
) (
  input  logic [num_req_p-1:0] v_i,
  input  logic [idx_w_lp-1:0]  ptr_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [idx_w_lp-1:0]  idx_o,
  output logic                 found_o
);

  logic                found;
  logic [idx_w_lp-1:0] idx;
  int                  j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < num_req_p; i++) begin
      j = int'(ptr_i) + i;
      if (j >= num_req_p) j = j - num_req_p;
      if (!found && v_i[j]) begin
        found = 1'b1;
        idx   = idx_w_lp'(j);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (found) grant_o[idx] = 1'b1;
  end

  assign idx_o   = idx;
  assign found_o = found;

endmodule

// File: rtl/bsg_credit_rr_sender.sv
// Round-robin arbiter feeding a credit-flow-controlled FIFO; v_o/data_o one cycle after yumi_o.
// Grants only with a credit in hand, so the FIFO never back-pressures; optional BSG_CREDIT_RR_SENDER_STALL_STATS_EN adds stall_cnt_o.
module bsg_credit_rr_sender
  import bsg_credit_rr_pkg::*;
#(
  parameter  int num_req_p = 4,
  parameter  int width_p   = 64,
  parameter  int els_p     = 500,
  localparam int cnt_w_lp  = credit_cnt_w(els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_req_p-1:0]         v_i,
  input  logic [num_req_p*width_p-1:0] data_i,
  output logic [num_req_p-1:0]         yumi_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         credit_i,
  input  logic                         drain_i,
  output logic                         drained_o,
  output logic [cnt_w_lp-1:0]          credits_o,
  output logic                         err_o
`ifdef BSG_CREDIT_RR_SENDER_STALL_STATS_EN
  ,output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int                  idx_w_lp = idx_w(num_req_p);
  localparam logic [cnt_w_lp-1:0] els_lp   = cnt_w_lp'(els_p);
  localparam logic [idx_w_lp-1:0] last_lp  = idx_w_lp'(num_req_p - 1);

  rr_state_e             state_r, state_n;
  logic [cnt_w_lp-1:0]   credits_r, credits_n;
  logic [idx_w_lp-1:0]   ptr_r, ptr_n;
  logic [idx_w_lp-1:0]   win_idx;
  logic [num_req_p-1:0]  win_oh;
  logic                  win_vld;
  logic                  grant;
  logic                  overflow;

  bsg_rr_pick #(.num_req_p(num_req_p)) pick (
    .v_i     (v_i),
    .ptr_i   (ptr_r),
    .grant_o (win_oh),
    .idx_o   (win_idx),
    .found_o (win_vld)
  );

  // Registered state gates the grant, so a drain request arriving this cycle does not stop it.
  assign grant    = (state_r == RUN) && (credits_r != '0) && win_vld;
  assign yumi_o   = grant ? win_oh : '0;
  assign overflow = credit_i && !grant && (credits_r == els_lp);

  always_comb begin
    ptr_n = ptr_r;
    if (grant) ptr_n = (win_idx == last_lp) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    credits_n = credits_r;
    if (overflow)               credits_n = els_lp;
    else if (grant && !credit_i) credits_n = credits_r - 1'b1;
    else if (!grant && credit_i) credits_n = credits_r + 1'b1;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      RUN:     if (drain_i) state_n = DRAIN;
      DRAIN: begin
        if (!drain_i)                            state_n = RUN;
        else if (credits_r == els_lp && !v_o)    state_n = DRAINED;
      end
      DRAINED: if (!drain_i) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= RUN;
      credits_r <= els_lp;
      ptr_r     <= '0;
      v_o       <= 1'b0;
      data_o    <= '0;
      err_o     <= 1'b0;
    end else begin
      state_r   <= state_n;
      credits_r <= credits_n;
      ptr_r     <= ptr_n;
      v_o       <= grant;
      if (grant)    data_o <= data_i[win_idx*width_p +: width_p];
      if (overflow) err_o  <= 1'b1;
    end
  end

  assign drained_o = (state_r == DRAINED);
  assign credits_o = credits_r;

`ifdef BSG_CREDIT_RR_SENDER_STALL_STATS_EN
  logic stall;
  assign stall = (state_r == RUN) && (|v_i) && (credits_r == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                       stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1)  stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_bsg_credit_rr_sender.sv
// Bench for bsg_credit_rr_sender: directed vector table, async reset sequence, randomized run vs reference model.
module tb_bsg_credit_rr_sender;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int ELS = 4;
  localparam int CW  = $clog2(ELS + 1);

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           credit_i;
  logic           drain_i;
  logic           drained_o;
  logic [CW-1:0]  credits_o;
  logic           err_o;
`ifdef BSG_CREDIT_RR_SENDER_STALL_STATS_EN
  logic [31:0]    stall_cnt_o;
`endif

  bsg_credit_rr_sender #(.num_req_p(N), .width_p(W), .els_p(ELS)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .yumi_o    (yumi_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .credit_i  (credit_i),
    .drain_i   (drain_i),
    .drained_o (drained_o),
    .credits_o (credits_o),
    .err_o     (err_o)
`ifdef BSG_CREDIT_RR_SENDER_STALL_STATS_EN
    ,.stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0=run, 1=drain, 2=drained.
  int           m_cred, m_ptr, m_mode;
  logic         m_vo, m_err;
  logic [W-1:0] m_data;
  longint       m_stall;

  typedef struct {
    logic [N-1:0] v;
    logic         cr;
    logic         dr;
    logic [N-1:0] exp_yumi;
    int           exp_cred;
    logic         exp_drained;
    logic         exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred  = ELS;
    m_ptr   = 0;
    m_mode  = 0;
    m_vo    = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_regs();
    chk("v_o", v_o, m_vo);
    chk("data_o", data_o, m_data);
    chk("credits_o", credits_o, m_cred);
    chk("drained_o", drained_o, m_mode == 2);
    chk("err_o", err_o, m_err);
`ifdef BSG_CREDIT_RR_SENDER_STALL_STATS_EN
    chk("stall_cnt_o", stall_cnt_o, m_stall);
`endif
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic cr, input logic dr, output logic [N-1:0] y);
    int win;
    int r;
    logic [N-1:0] exp_y;
    check_regs();
    v_i      = v;
    credit_i = cr;
    drain_i  = dr;
    data_i   = {$urandom(), $urandom()};
    #1;
    win = -1;
    if (m_mode == 0 && m_cred > 0)
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (win < 0 && v[r]) win = r;
      end
    exp_y = '0;
    if (win >= 0) exp_y[win] = 1'b1;
    y = yumi_o;
    chk("yumi_o", yumi_o, exp_y);
    if (m_mode == 0 && v != 0 && m_cred == 0 && m_stall < 64'hffff_ffff) m_stall++;
    case (m_mode)
      0: if (dr) m_mode = 1;
      1: if (!dr) m_mode = 0; else if (m_cred == ELS && !m_vo) m_mode = 2;
      default: if (!dr) m_mode = 0;
    endcase
    m_cred = m_cred - ((win >= 0) ? 1 : 0) + (cr ? 1 : 0);
    if (m_cred > ELS) begin
      m_cred = ELS;
      m_err  = 1'b1;
    end
    m_vo = (win >= 0);
    if (win >= 0) begin
      m_data = data_i[win*W +: W];
      m_ptr  = (win + 1) % N;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic add(input logic [N-1:0] v, input logic cr, input logic dr, input logic [N-1:0] ey,
                     input int ec, input logic ed, input logic ee);
    vec_t t;
    t.v = v; t.cr = cr; t.dr = dr; t.exp_yumi = ey; t.exp_cred = ec; t.exp_drained = ed; t.exp_err = ee;
    tbl.push_back(t);
  endtask

  initial begin
    logic [N-1:0] y;
    logic dr;

    // Credits drain 4..0 with rotating grants, then starvation.
    add(4'b1111, 0, 0, 4'b0001, 3, 0, 0);
    add(4'b1111, 0, 0, 4'b0010, 2, 0, 0);
    add(4'b1111, 0, 0, 4'b0100, 1, 0, 0);
    add(4'b1111, 0, 0, 4'b1000, 0, 0, 0);
    add(4'b1111, 0, 0, 4'b0000, 0, 0, 0);
    // Credit returning at zero cannot be spent in the same cycle.
    add(4'b0100, 1, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 0, 0, 4'b0100, 0, 0, 0);
    // Grant plus credit together leaves the count alone.
    add(4'b0000, 1, 0, 4'b0000, 1, 0, 0);
    add(4'b0000, 1, 0, 4'b0000, 2, 0, 0);
    add(4'b0010, 1, 0, 4'b0010, 2, 0, 0);
    // Pointer at 2 wraps to requester 0, then 1.
    add(4'b0011, 0, 0, 4'b0001, 1, 0, 0);
    add(4'b0011, 0, 0, 4'b0010, 0, 0, 0);
    // Drain sequence.
    add(4'b0000, 1, 0, 4'b0000, 1, 0, 0);
    add(4'b0000, 0, 1, 4'b0000, 1, 0, 0);
    add(4'b1111, 1, 1, 4'b0000, 2, 0, 0);
    add(4'b1111, 1, 1, 4'b0000, 3, 0, 0);
    add(4'b1111, 1, 1, 4'b0000, 4, 0, 0);
    add(4'b1111, 0, 1, 4'b0000, 4, 1, 0);
    add(4'b1111, 0, 0, 4'b0000, 4, 0, 0);
    add(4'b1111, 0, 0, 4'b0100, 3, 0, 0);
    // Spurious credit at full count.
    add(4'b0000, 1, 0, 4'b0000, 4, 0, 0);
    add(4'b0000, 1, 0, 4'b0000, 4, 0, 1);
    add(4'b0000, 0, 0, 4'b0000, 4, 0, 1);

    v_i = '0; credit_i = 1'b0; drain_i = 1'b0; data_i = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_regs();
    chk("reset yumi_o", yumi_o, '0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].cr, tbl[i].dr, y);
      chk($sformatf("tbl[%0d] yumi", i), y, tbl[i].exp_yumi);
      chk($sformatf("tbl[%0d] credits", i), credits_o, tbl[i].exp_cred);
      chk($sformatf("tbl[%0d] drained", i), drained_o, tbl[i].exp_drained);
      chk($sformatf("tbl[%0d] err", i), err_o, tbl[i].exp_err);
    end

    // Asynchronous reset while a write is on the output.
    step(4'b1111, 0, 0, y);
    chk("pre-reset yumi", y, 4'b1000);
    chk("pre-reset v_o", v_o, 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async v_o", v_o, 1'b0);
    chk("async credits", credits_o, ELS);
    chk("async err", err_o, 1'b0);
    chk("async data", data_o, '0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(4'b0110, 0, 0, y);
    chk("post-reset yumi", y, 4'b0010);

    dr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) dr = ~dr;
      step(N'($urandom()), ($urandom_range(0, 2) == 0) || (dr && $urandom_range(0, 1) == 0), dr, y);
    end
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
